// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register.
// Mode selects and the burst controller states.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_ctl_if.sv
// Command/status bundle of the universal shift register.
// master issues commands, slave is the register.
interface shift_reg_ctl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             en;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] load_val;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output en, start, mode, shift_cnt,
    output load_val, ser_in,
    input  q, ser_out, busy, done
  );

  modport slave (
    input  en, start, mode, shift_cnt,
    input  load_val, ser_in,
    output q, ser_out, busy, done
  );

endinterface

// File: rtl/shift_reg_next.sv
// Next-value logic for one register operation.
// Shared by single-step and burst paths.
module shift_reg_next
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit,
  output logic             out_valid
);

  always_comb begin
    next_q    = q;
    out_bit   = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (mode == MODE_LOAD): begin
        next_q = load_val;
      end
      (mode == MODE_SHL): begin
        next_q    = {q[WIDTH-2:0], ser_in};
        out_bit   = q[WIDTH-1];
        out_valid = 1'b1;
      end
      (mode == MODE_SHR): begin
        next_q    = {ser_in, q[WIDTH-1:1]};
        out_bit   = q[0];
        out_valid = 1'b1;
      end
      (mode == MODE_ROL): begin
        next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit   = q[WIDTH-1];
        out_valid = 1'b1;
      end
      (mode == MODE_ROR): begin
        next_q    = {q[0], q[WIDTH-1:1]};
        out_bit   = q[0];
        out_valid = 1'b1;
      end
      default: begin
        next_q = q;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_ctl.sv
// Universal register: single-step ops or counted bursts.
// Holds the burst FSM, counter, latched mode and outputs.
module shift_reg_ctl
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             reset_n,
  shift_reg_ctl_if.slave  bus
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       mode_q, mode_n;
  logic [2:0]       op_mode;
  logic             apply;

  logic [WIDTH-1:0] q_r;
  logic             so_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] next_q;
  logic             out_bit;
  logic             out_valid;

  shift_reg_next #(.WIDTH(WIDTH)) u_next (
    .q         (q_r),
    .mode      (op_mode),
    .ser_in    (bus.ser_in),
    .load_val  (bus.load_val),
    .next_q    (next_q),
    .out_bit   (out_bit),
    .out_valid (out_valid)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_q;
    op_mode = bus.mode;
    apply   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          mode_n = bus.mode;
          cnt_n  = bus.shift_cnt;
          if (bus.shift_cnt != '0) begin
            state_n = RUN;
          end else begin
            state_n = DONE;
          end
        end else if (bus.en) begin
          apply = 1'b1;
        end
      end
      RUN: begin
        op_mode = mode_q;
        apply   = 1'b1;
        cnt_n   = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Status flags are flopped from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= MODE_HOLD;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mode_q <= mode_n;
      busy_r <= (state_n == RUN);
      done_r <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r  <= '0;
      so_r <= 1'b0;
    end else if (apply) begin
      q_r <= next_q;
      if (out_valid) begin
        so_r <= out_bit;
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.ser_out = so_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_shift_reg_ctl.sv
// Directed bench for shift_reg_ctl with an expectation queue.
// Expectations are queued at drive time, popped after the edge.
module tb_shift_reg_ctl;

  localparam int W = 8;
  localparam int C = 4;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4;
  localparam logic [2:0] M_ROR  = 3'd5;

  typedef struct {
    string     tag;
    logic [10:0] v;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  shift_reg_ctl_if #(.WIDTH(W), .CNT_W(C)) bus ();

  shift_reg_ctl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic push(input string tag, input logic [7:0] q,
                      input logic so, input logic b,
                      input logic d);
    exp_t e;
    e.tag = tag;
    e.v   = {q, so, b, d};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [10:0] obs;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed=0 entries required=1");
      return;
    end
    e   = sb.pop_front();
    obs = {bus.q, bus.ser_out, bus.busy, bus.done};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed q=%h so=%b busy=%b done=%b required q=%h so=%b busy=%b done=%b",
             e.tag, obs[10:3], obs[2], obs[1], obs[0],
             e.v[10:3], e.v[2], e.v[1], e.v[0]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic [7:0] q,
                      input logic so, input logic b,
                      input logic d);
    push(tag, q, so, b, d);
    cyc();
    pop_check();
  endtask

  task automatic idle_in();
    bus.en        = 1'b0;
    bus.start     = 1'b0;
    bus.mode      = M_HOLD;
    bus.shift_cnt = '0;
    bus.load_val  = '0;
    bus.ser_in    = 1'b0;
  endtask

  logic [7:0] pat;

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    idle_in();
    #1;
    push("reset_now", 8'h00, 1'b0, 1'b0, 1'b0);
    pop_check();
    cyc();
    step("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step("idle_after_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    // single-step load and shifts
    bus.en = 1'b1;
    bus.mode = M_LOAD;
    bus.load_val = 8'hA5;
    step("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    bus.mode = M_SHL;
    bus.ser_in = 1'b1;
    step("shl_si1", 8'h4B, 1'b1, 1'b0, 1'b0);
    bus.mode = M_SHR;
    bus.ser_in = 1'b0;
    step("shr_si0", 8'h25, 1'b1, 1'b0, 1'b0);

    // rotate burst ROR x3 from 81
    bus.mode = M_LOAD;
    bus.load_val = 8'h81;
    step("load_81", 8'h81, 1'b1, 1'b0, 1'b0);
    bus.en = 1'b0;
    bus.start = 1'b1;
    bus.mode = M_ROR;
    bus.shift_cnt = 4'd3;
    step("ror_start", 8'h81, 1'b1, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.mode = M_HOLD;
    bus.shift_cnt = 4'd0;
    step("ror_op1", 8'hC0, 1'b1, 1'b1, 1'b0);
    step("ror_op2", 8'h60, 1'b0, 1'b1, 1'b0);
    step("ror_op3", 8'h30, 1'b0, 1'b0, 1'b1);
    step("ror_after", 8'h30, 1'b0, 1'b0, 1'b0);

    // zero-count burst
    bus.start = 1'b1;
    bus.mode = M_SHL;
    bus.shift_cnt = 4'd0;
    bus.ser_in = 1'b1;
    step("zero_done", 8'h30, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b0;
    step("zero_clear", 8'h30, 1'b0, 1'b0, 1'b0);

    // commands during a SHL burst are ignored
    bus.start = 1'b1;
    bus.mode = M_SHL;
    bus.shift_cnt = 4'd2;
    bus.ser_in = 1'b0;
    step("shl2_start", 8'h30, 1'b0, 1'b1, 1'b0);
    bus.en = 1'b1;
    bus.mode = M_LOAD;
    bus.load_val = 8'hFF;
    bus.shift_cnt = 4'd7;
    step("ign_op1", 8'h60, 1'b0, 1'b1, 1'b0);
    step("ign_op2", 8'hC0, 1'b0, 1'b0, 1'b1);
    step("ign_in_done", 8'hC0, 1'b0, 1'b0, 1'b0);

    // start beats en in the same idle cycle
    bus.start = 1'b1;
    bus.en = 1'b1;
    bus.mode = M_ROL;
    bus.shift_cnt = 4'd1;
    step("start_wins", 8'hC0, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    bus.en = 1'b0;
    step("rol1_done", 8'h81, 1'b1, 1'b0, 1'b1);
    step("rol1_idle", 8'h81, 1'b1, 1'b0, 1'b0);

    // SHL x8 with live serial input
    bus.en = 1'b1;
    bus.mode = M_LOAD;
    bus.load_val = 8'h00;
    step("load_00", 8'h00, 1'b1, 1'b0, 1'b0);
    bus.en = 1'b0;
    bus.start = 1'b1;
    bus.mode = M_SHL;
    bus.shift_cnt = 4'd8;
    step("shl8_start", 8'h00, 1'b1, 1'b1, 1'b0);
    bus.start = 1'b0;
    pat = 8'b1011_0010;
    bus.ser_in = pat[7];
    step("shl8_1", 8'h01, 1'b0, 1'b1, 1'b0);
    bus.ser_in = pat[6];
    step("shl8_2", 8'h02, 1'b0, 1'b1, 1'b0);
    bus.ser_in = pat[5];
    step("shl8_3", 8'h05, 1'b0, 1'b1, 1'b0);
    bus.ser_in = pat[4];
    step("shl8_4", 8'h0B, 1'b0, 1'b1, 1'b0);
    bus.ser_in = pat[3];
    step("shl8_5", 8'h16, 1'b0, 1'b1, 1'b0);
    bus.ser_in = pat[2];
    step("shl8_6", 8'h2C, 1'b0, 1'b1, 1'b0);
    bus.ser_in = pat[1];
    step("shl8_7", 8'h59, 1'b0, 1'b1, 1'b0);
    bus.ser_in = pat[0];
    step("shl8_8", 8'hB2, 1'b0, 1'b0, 1'b1);
    step("shl8_idle", 8'hB2, 1'b0, 1'b0, 1'b0);

    // unused mode codes hold
    bus.en = 1'b1;
    bus.mode = 3'd6;
    bus.ser_in = 1'b1;
    step("mode6_hold", 8'hB2, 1'b0, 1'b0, 1'b0);
    bus.mode = 3'd7;
    step("mode7_hold", 8'hB2, 1'b0, 1'b0, 1'b0);
    bus.mode = M_HOLD;
    step("mode0_hold", 8'hB2, 1'b0, 1'b0, 1'b0);

    // async reset in the middle of a ROL x5 burst
    bus.mode = M_LOAD;
    bus.load_val = 8'h81;
    step("load_81b", 8'h81, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b0;
    bus.start = 1'b1;
    bus.mode = M_ROL;
    bus.shift_cnt = 4'd5;
    step("rol5_start", 8'h81, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    step("rol5_op1", 8'h03, 1'b1, 1'b1, 1'b0);
    step("rol5_op2", 8'h06, 1'b0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    push("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    pop_check();
    @(negedge clk);
    step("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step("post_rst1", 8'h00, 1'b0, 1'b0, 1'b0);
    step("post_rst2", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b1;
    bus.mode = M_LOAD;
    bus.load_val = 8'h3C;
    step("post_rst_load", 8'h3C, 1'b0, 1'b0, 1'b0);
    idle_in();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_left: observed=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctl.md
# shift_reg_ctl

Parametrised universal register generalising the single-bit D flip-flop into a WIDTH-bit register with a selectable operation mode. Modes are hold, parallel load, logical shift left/right with serial input, and rotate left/right. Supports single-step operation or an autonomous burst of N repeated operations with busy/done status. Used as a general storage, serialiser and deserialiser element in datapaths built from the flip-flop primitive.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of the burst count input; maximum burst length 2^CNT_W − 1

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  single-step strobe; performs one `mode` operation
- start  input  1  burst request; repeats `mode` `shift_cnt` times
- mode  input  3  operation select (encoding below)
- shift_cnt  input  CNT_W  burst length, sampled with `start`
- load_val  input  WIDTH  parallel load value
- ser_in  input  1  serial fill bit for logical shifts
- q  output  WIDTH  register contents
- ser_out  output  1  registered copy of the last bit shifted or rotated out
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse after the last burst operation

## Operation
- Mode encoding:
  - 0 HOLD
  - 1 LOAD (q←load_val)
  - 2 SHL (q←{q[W-2:0],ser_in})
  - 3 SHR (q←{ser_in,q[W-1:1]})
  - 4 ROL (q←{q[W-2:0],q[W-1]})
  - 5 ROR (q←{q[0],q[W-1:1]})
  - 6, 7: treated as HOLD
- ser_out updates only on SHL/ROL (takes q[W-1]) and SHR/ROR (takes q[0]); it holds otherwise.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 latches `mode` and `shift_cnt`.
    - Nonzero count → RUN.
    - Zero count → DONE with no operation.
    - Otherwise, if `en`=1, one operation is applied using the live `mode`.
  - RUN: each cycle applies the latched mode using the live `ser_in`/`load_val`, and decrements the remaining count. The operation that brings the count to 0 transitions the FSM to DONE.
  - DONE: lasts one cycle, then returns to IDLE. A `start` or `en` in DONE is ignored.
- `start` and `en` in the same IDLE cycle: `start` wins; `en` is dropped.
- While busy, `en`, `start`, `mode` and `shift_cnt` are ignored. The burst uses the latched mode.
- A burst with LOAD or HOLD is legal: it repeats that operation and reports done as normal.

## Timing
- Reset (asynchronous, any state including mid-burst): q=0, ser_out=0, busy=0, done=0, FSM=IDLE, count=0.
- Single step: `en` sampled at edge k → new q and ser_out visible after edge k.
- Burst of N≥1 with `start` sampled at edge 0:
  - busy=1 after edge 0.
  - Operations occur at edges 1..N.
  - After edge N: busy=0 and done=1.
  - After edge N+1: done=0 and the FSM accepts new commands.
- Burst of N=0: busy stays 0, done=1 after edge 0, q unchanged.
- busy and done are never high simultaneously.
- All outputs are registered; there is no combinational input→output path.

## Structure
- Package `shift_reg_pkg`:
  - mode encoding constants (MODE_HOLD…MODE_ROR)
  - FSM state encoding (IDLE, RUN, DONE)
- Sub-module `shift_reg_next` (purely combinational): (q, mode, ser_in, load_val) → (next_q, out_bit, out_valid). It is shared by the single-step and burst paths.
- The top level holds the FSM, burst counter, latched mode, and the q/ser_out registers.

## Test plan
- **Reset:** assert reset_n=0 asynchronously mid-burst (ROL, cnt=5, after 2 ops) → q=0, busy=0, done=0, ser_out=0 immediately. After release the register is idle.
- **Single-step shift:** LOAD 8'hA5 via en, then SHL with ser_in=1 → q=8'h4B, ser_out=1. Then SHR with ser_in=0 → q=8'h25, ser_out=1.
- **Rotate burst:** q=8'h81, start ROR cnt=3 → q sequence C0, 60, 30. busy is high for 3 cycles after the start edge, done pulses once, and final ser_out=0.
- **Zero-count burst:** start with cnt=0 → done=1 for exactly one cycle, busy never asserts, q unchanged.
- **Ignored commands:** during a SHL burst, pulse en with mode=LOAD and start → q follows SHL only and the burst length is unchanged. `start` and `en` in the same IDLE cycle → only the burst executes.
- **Burst with live ser_in:** SHL cnt=8 from 8'h00 with ser_in pattern 1,0,1,1,0,0,1,0 → q=8'hB2. Mode 6 in single step → q holds.
